sys_boot_ctrl: RTL and testbench
================================

Name: sys_boot_ctrl

Overview:
System controller for the simple processor system. It sequences processor reset, streams a program into instruction memory through a valid/ready port, and releases the core. It then counts execution cycles, detects halt (jump-to-self) and enforces a watchdog timeout. It sits between the host/bench and the processor, instruction-memory write port and reset.

Parameters:
INS_WIDTH, 12, instruction word width (opcode + address field)
INSADDR_WIDTH, 8, instruction memory address width; program depth = 2**INSADDR_WIDTH
CYC_WIDTH, 32, cycle counter width
HALT_CYCLES, 4, consecutive cycles instr_addr must hold the same value to declare halt (>=2)
WDOG_LIMIT, 100000, run-cycle timeout; must be < 2**CYC_WIDTH

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins load from IDLE, DONE or ERR
abort  in  1  level; forces ERR from LOAD or RUN
ld_valid  in  1  program word valid
ld_ready  out  1  controller accepts word
ld_data  in  INS_WIDTH  program word
ld_last  in  1  marks final word of program
imem_wr  out  1  instruction memory write strobe
imem_addr  out  INSADDR_WIDTH  instruction memory write address
imem_wdata  out  INS_WIDTH  instruction memory write data
instr_addr  in  INSADDR_WIDTH  processor fetch address (monitor only)
cpu_rst  out  1  active-high reset to processor
busy  out  1  high in LOAD or RUN
done  out  1  high in DONE
err  out  1  high in ERR
err_code  out  2  0 none, 1 overflow, 2 timeout, 3 abort
prog_len  out  INSADDR_WIDTH+1  words loaded in last load
cycles  out  CYC_WIDTH  cycles spent in RUN

Behaviour:
- Reset (rst low, async): state IDLE; cpu_rst=1, ld_ready=0, imem_wr=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0, err_code=0, prog_len=0, cycles=0.
- States: IDLE, LOAD, RUN, DONE, ERR. All outputs registered.
- IDLE/DONE/ERR: start -> LOAD; clears prog_len, cycles, err_code; cpu_rst stays 1. start is ignored in LOAD/RUN.
- LOAD: ld_ready=1. A transfer occurs when ld_valid&&ld_ready. The next cycle has imem_wr=1, imem_addr=word index (0,1,...), imem_wdata=ld_data, and prog_len incremented. No bubbles: one word per cycle sustained.
- LOAD, transfer with ld_last: the word is written and the state moves to RUN. ld_ready drops in the cycle after the last transfer.
- Overflow: a transfer when prog_len == 2**INSADDR_WIDTH is not written; state goes to ERR, err_code=1. A final word landing exactly at the last address is legal.
- ld_last without ld_valid is ignored.
- RUN: cpu_rst=0 from the first RUN cycle. cycles increments every RUN cycle, saturating at all-ones.
- Halt detector: counts consecutive cycles where instr_addr equals its previous-cycle value. The count resets on change and on RUN entry. When it reaches HALT_CYCLES -> DONE. cpu_rst reasserts in the same transition.
- Timeout: cycles == WDOG_LIMIT -> ERR, err_code=2, cpu_rst=1.
- abort high in LOAD or RUN -> ERR, err_code=3, cpu_rst=1. Priority: abort > overflow/timeout > halt/ld_last completion.
- done and err are levels held until the next start. cycles and prog_len hold in DONE/ERR.
- Async reset mid-LOAD or mid-RUN: immediate return to reset values. Partially written memory is not cleared.

Test Plan:
- Load 5 words 0x101..0x105 back-to-back, last on 5th -> imem_wr 5 consecutive cycles at addr 0..4 with matching data; prog_len=5; state RUN; cpu_rst falls.
- ld_valid toggled every other cycle over 3 words -> exactly 3 writes at addr 0,1,2; no duplicate or dropped write; ld_ready stays 1 until after the last transfer.
- RUN with instr_addr 0,1,2,3,then 3 held, HALT_CYCLES=4 -> done=1 after the 4th identical cycle; cpu_rst=1; cycles frozen at the value recorded at halt.
- Stream 257 words, INSADDR_WIDTH=8, no ld_last -> 256 writes; 257th not written; err=1, err_code=1; then start -> LOAD, err cleared, prog_len=0.
- WDOG_LIMIT=50, instr_addr incrementing -> err_code=2 at cycles=50; cpu_rst=1.
- abort asserted mid-LOAD after 2 words -> err_code=3 next cycle; rst pulsed low mid-RUN -> all outputs at reset values immediately, asynchronously.

Source files
------------

// File: rtl/sys_boot_ctrl.sv
// Boot/run controller: holds the core in reset, streams a program into instruction memory,
// releases the core, then watches for halt (jump-to-self), watchdog timeout or abort.
module sys_boot_ctrl #(
   parameter int unsigned INS_WIDTH     = 12,
   parameter int unsigned INSADDR_WIDTH = 8,
   parameter int unsigned CYC_WIDTH     = 32,
   parameter int unsigned HALT_CYCLES   = 4,
   parameter int unsigned WDOG_LIMIT    = 100000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     abort,
   input  logic                     ld_valid,
   output logic                     ld_ready,
   input  logic [INS_WIDTH-1:0]     ld_data,
   input  logic                     ld_last,
   output logic                     imem_wr,
   output logic [INSADDR_WIDTH-1:0] imem_addr,
   output logic [INS_WIDTH-1:0]     imem_wdata,
   input  logic [INSADDR_WIDTH-1:0] instr_addr,
   output logic                     cpu_rst,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output logic [1:0]               err_code,
   output logic [INSADDR_WIDTH:0]   prog_len,
   output logic [CYC_WIDTH-1:0]     cycles
);

   localparam int unsigned HCW = $clog2(HALT_CYCLES + 1);
   localparam logic [INSADDR_WIDTH:0] DEPTH  = {1'b1, {INSADDR_WIDTH{1'b0}}};
   localparam logic [CYC_WIDTH-1:0]   WDOG   = CYC_WIDTH'(WDOG_LIMIT);
   localparam logic [HCW-1:0]         HALT_N = HCW'(HALT_CYCLES);

   typedef enum logic [2:0] {StIdle, StLoad, StRun, StDone, StErr} state_t;

   state_t                     r_state, w_state_d;
   logic                       r_ld_ready, r_imem_wr, r_cpu_rst, r_busy, r_done, r_err;
   logic [INSADDR_WIDTH-1:0]   r_imem_addr, r_prev_addr;
   logic [INS_WIDTH-1:0]       r_imem_wdata;
   logic [1:0]                 r_err_code, w_err_code_d;
   logic [INSADDR_WIDTH:0]     r_prog_len, w_prog_len_d;
   logic [CYC_WIDTH-1:0]       r_cycles, w_cycles_d, w_cyc_inc;
   logic [HCW-1:0]             r_halt_cnt, w_halt_cnt_d, w_halt_inc;
   logic                       w_xfer, w_wr;

   always_comb begin
      w_state_d    = r_state;
      w_err_code_d = r_err_code;
      w_prog_len_d = r_prog_len;
      w_cycles_d   = r_cycles;
      w_halt_cnt_d = r_halt_cnt;
      w_wr         = 1'b0;
      w_xfer       = ld_valid & r_ld_ready;
      w_cyc_inc    = (r_cycles == '1) ? r_cycles : r_cycles + 1'b1;
      w_halt_inc   = (instr_addr == r_prev_addr) ? r_halt_cnt + 1'b1 : '0;
      unique case (r_state)
         StIdle, StDone, StErr: begin
            if (start) begin
               w_state_d    = StLoad;
               w_prog_len_d = '0;
               w_cycles_d   = '0;
               w_err_code_d = 2'd0;
               w_halt_cnt_d = '0;
            end
         end
         StLoad: begin
            if (abort) begin
               w_state_d    = StErr;
               w_err_code_d = 2'd3;
            end else if (w_xfer) begin
               // A full memory rejects the word instead of wrapping onto address 0
               if (r_prog_len == DEPTH) begin
                  w_state_d    = StErr;
                  w_err_code_d = 2'd1;
               end else begin
                  w_wr         = 1'b1;
                  w_prog_len_d = r_prog_len + 1'b1;
                  if (ld_last) begin
                     w_state_d    = StRun;
                     w_halt_cnt_d = '0;
                  end
               end
            end
         end
         StRun: begin
            if (abort) begin
               w_state_d    = StErr;
               w_err_code_d = 2'd3;
            end else begin
               // cycles counts every RUN cycle, including the one that leaves RUN
               w_cycles_d   = w_cyc_inc;
               w_halt_cnt_d = w_halt_inc;
               if (w_cyc_inc == WDOG) begin
                  w_state_d    = StErr;
                  w_err_code_d = 2'd2;
               end else if (w_halt_inc == HALT_N) begin
                  w_state_d = StDone;
               end
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= StIdle;
         r_ld_ready   <= 1'b0;
         r_imem_wr    <= 1'b0;
         r_imem_addr  <= '0;
         r_imem_wdata <= '0;
         r_cpu_rst    <= 1'b1;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_err_code   <= 2'd0;
         r_prog_len   <= '0;
         r_cycles     <= '0;
         r_halt_cnt   <= '0;
         r_prev_addr  <= '0;
      end else begin
         r_state      <= w_state_d;
         r_ld_ready   <= (w_state_d == StLoad);
         r_imem_wr    <= w_wr;
         if (w_wr) begin
            r_imem_addr  <= r_prog_len[INSADDR_WIDTH-1:0];
            r_imem_wdata <= ld_data;
         end
         r_cpu_rst    <= (w_state_d != StRun);
         r_busy       <= (w_state_d == StLoad) || (w_state_d == StRun);
         r_done       <= (w_state_d == StDone);
         r_err        <= (w_state_d == StErr);
         r_err_code   <= w_err_code_d;
         r_prog_len   <= w_prog_len_d;
         r_cycles     <= w_cycles_d;
         r_halt_cnt   <= w_halt_cnt_d;
         r_prev_addr  <= instr_addr;
      end
   end

   assign ld_ready   = r_ld_ready;
   assign imem_wr    = r_imem_wr;
   assign imem_addr  = r_imem_addr;
   assign imem_wdata = r_imem_wdata;
   assign cpu_rst    = r_cpu_rst;
   assign busy       = r_busy;
   assign done       = r_done;
   assign err        = r_err;
   assign err_code   = r_err_code;
   assign prog_len   = r_prog_len;
   assign cycles     = r_cycles;

endmodule

// File: tb/tb_sys_boot_ctrl.sv
// Bench for sys_boot_ctrl: scenario tasks plus a write scoreboard on the imem port.
module tb_sys_boot_ctrl;

   localparam int IW = 12;
   localparam int AW = 8;
   localparam int CW = 32;

   logic          clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
   logic          ld_valid = 1'b0, ld_last = 1'b0;
   logic [IW-1:0] ld_data = '0;
   logic [AW-1:0] instr_addr = '0;
   logic          ld_ready, imem_wr, cpu_rst, busy, done, err;
   logic [AW-1:0] imem_addr;
   logic [IW-1:0] imem_wdata;
   logic [1:0]    err_code;
   logic [AW:0]   prog_len;
   logic [CW-1:0] cycles;

   int n_checks = 0, n_fail = 0, n_writes = 0;
   logic [AW+IW-1:0] exp_q[$];
   logic [AW+IW-1:0] mon_exp;

   sys_boot_ctrl #(
      .INS_WIDTH(IW), .INSADDR_WIDTH(AW), .CYC_WIDTH(CW), .HALT_CYCLES(4), .WDOG_LIMIT(50)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
      .imem_wr(imem_wr), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .instr_addr(instr_addr), .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err),
      .err_code(err_code), .prog_len(prog_len), .cycles(cycles)
   );

   always #5 clk = ~clk;

   // Scoreboard: every observed write must match the oldest expected one
   always @(negedge clk) begin
      if (rst && imem_wr) begin
         n_writes++;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: got addr=%0h data=%0h, expected no write",
                     imem_addr, imem_wdata);
         end else begin
            mon_exp = exp_q.pop_front();
            if ({imem_addr, imem_wdata} !== mon_exp) begin
               n_fail++;
               $display("FAIL write_data: got addr=%0h data=%0h, expected addr=%0h data=%0h",
                        imem_addr, imem_wdata, mon_exp[AW+IW-1:IW], mon_exp[IW-1:0]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      n_writes = 0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      n_checks++;
      if ({cpu_rst, ld_ready, imem_wr, busy, done, err} !== 6'b100000 || err_code !== 2'd0 ||
          prog_len !== '0 || cycles !== '0 || imem_addr !== '0 || imem_wdata !== '0) begin
         n_fail++;
         $display("FAIL reset_state: got flags=%b code=%0d len=%0d cyc=%0d, expected 100000/0/0/0",
                  {cpu_rst, ld_ready, imem_wr, busy, done, err}, err_code, prog_len, cycles);
      end
      rst = 1'b1;
      tick();
      n_checks++;
      if ({cpu_rst, busy, ld_ready} !== 3'b100) begin
         n_fail++;
         $display("FAIL idle_hold: got cpu_rst/busy/ready=%b, expected 100", {cpu_rst, busy, ld_ready});
      end
   endtask

   task automatic test_load_back_to_back();
      do_start();
      n_checks++;
      if ({ld_ready, busy, cpu_rst, done, err} !== 5'b11100) begin
         n_fail++;
         $display("FAIL load_entry: got ready/busy/cpu_rst/done/err=%b, expected 11100",
                  {ld_ready, busy, cpu_rst, done, err});
      end
      instr_addr = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         ld_valid = 1'b1;
         ld_data  = IW'(12'h101 + i);
         ld_last  = (i == 4);
         exp_q.push_back({AW'(i), ld_data});
         tick();
         n_checks++;
         if (imem_wr !== 1'b1 || imem_addr !== AW'(i)) begin
            n_fail++;
            $display("FAIL b2b_stream: got wr=%b addr=%0d, expected wr=1 addr=%0d", imem_wr, imem_addr, i);
         end
      end
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      n_checks++;
      if (prog_len !== 9'd5 || {busy, cpu_rst, ld_ready} !== 3'b100) begin
         n_fail++;
         $display("FAIL b2b_run_entry: got len=%0d busy/cpu_rst/ready=%b, expected 5 and 100",
                  prog_len, {busy, cpu_rst, ld_ready});
      end
   endtask

   task automatic test_halt();
      logic [AW-1:0] seq [8] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3};
      for (int k = 0; k < 8; k++) begin
         instr_addr = seq[k];
         tick();
         if (k == 0) begin
            n_checks++;
            if (n_writes !== 5 || exp_q.size() !== 0) begin
               n_fail++;
               $display("FAIL b2b_count: got writes=%0d pending=%0d, expected 5 and 0",
                        n_writes, exp_q.size());
            end
         end
         if (k == 6) begin
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b1) begin
               n_fail++;
               $display("FAIL halt_early: got done=%b busy=%b, expected 0 1", done, busy);
            end
         end
      end
      n_checks++;
      if (done !== 1'b1 || cpu_rst !== 1'b1 || busy !== 1'b0 || cycles !== 32'd8) begin
         n_fail++;
         $display("FAIL halt_detect: got done=%b cpu_rst=%b busy=%b cyc=%0d, expected 1 1 0 8",
                  done, cpu_rst, busy, cycles);
      end
      instr_addr = 8'd9;
      repeat (3) tick();
      n_checks++;
      if (done !== 1'b1 || cycles !== 32'd8) begin
         n_fail++;
         $display("FAIL halt_hold: got done=%b cyc=%0d, expected 1 8", done, cycles);
      end
   endtask

   task automatic test_toggle_valid();
      do_start();
      instr_addr = '0;
      for (int i = 0; i < 5; i++) begin
         ld_valid = (i % 2 == 0);
         ld_data  = IW'(12'h200 + i / 2);
         ld_last  = (i == 4);
         if (ld_valid) exp_q.push_back({AW'(i / 2), ld_data});
         tick();
         n_checks++;
         if (imem_wr !== ld_valid || ld_ready !== (i < 4)) begin
            n_fail++;
            $display("FAIL toggle_step%0d: got wr=%b ready=%b, expected wr=%b ready=%b",
                     i, imem_wr, ld_ready, ld_valid, (i < 4));
         end
      end
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      n_checks++;
      if (prog_len !== 9'd3 || cpu_rst !== 1'b0) begin
         n_fail++;
         $display("FAIL toggle_len: got len=%0d cpu_rst=%b, expected 3 0", prog_len, cpu_rst);
      end
   endtask

   task automatic test_timeout();
      int k;
      for (k = 1; k <= 60; k++) begin
         instr_addr = AW'(k);
         tick();
         if (err) break;
      end
      n_checks++;
      if (k !== 50 || n_writes !== 3 || exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL timeout_cycle: got err at run cycle %0d writes=%0d, expected 50 and 3",
                  k, n_writes);
      end
      n_checks++;
      if (err_code !== 2'd2 || cycles !== 32'd50 || cpu_rst !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_state: got code=%0d cyc=%0d cpu_rst=%b busy=%b, expected 2 50 1 0",
                  err_code, cycles, cpu_rst, busy);
      end
   endtask

   task automatic test_overflow();
      do_start();
      n_checks++;
      if (err !== 1'b0 || err_code !== 2'd0 || cycles !== '0 || ld_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL restart_clear: got err=%b code=%0d cyc=%0d ready=%b, expected 0 0 0 1",
                  err, err_code, cycles, ld_ready);
      end
      for (int i = 0; i <= 256; i++) begin
         ld_valid = 1'b1;
         ld_data  = IW'(i ^ 12'h5A5);
         if (i < 256) exp_q.push_back({AW'(i), ld_data});
         tick();
         if (i == 255) begin
            n_checks++;
            if (imem_wr !== 1'b1 || imem_addr !== 8'd255 || err !== 1'b0) begin
               n_fail++;
               $display("FAIL last_addr: got wr=%b addr=%0d err=%b, expected 1 255 0",
                        imem_wr, imem_addr, err);
            end
         end
      end
      ld_valid = 1'b0;
      n_checks++;
      if (err !== 1'b1 || err_code !== 2'd1 || imem_wr !== 1'b0 || prog_len !== 9'd256 ||
          ld_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL overflow: got err=%b code=%0d wr=%b len=%0d ready=%b, expected 1 1 0 256 0",
                  err, err_code, imem_wr, prog_len, ld_ready);
      end
      tick();
      n_checks++;
      if (n_writes !== 256 || exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL overflow_count: got writes=%0d pending=%0d, expected 256 0",
                  n_writes, exp_q.size());
      end
      do_start();
      n_checks++;
      if (err !== 1'b0 || err_code !== 2'd0 || prog_len !== '0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow_restart: got err=%b code=%0d len=%0d busy=%b, expected 0 0 0 1",
                  err, err_code, prog_len, busy);
      end
   endtask

   task automatic test_abort_load();
      for (int i = 0; i < 2; i++) begin
         ld_valid = 1'b1;
         ld_data  = IW'(12'h300 + i);
         exp_q.push_back({AW'(i), ld_data});
         tick();
      end
      abort   = 1'b1;
      ld_data = 12'h3FF;
      tick();
      abort    = 1'b0;
      ld_valid = 1'b0;
      n_checks++;
      if (err !== 1'b1 || err_code !== 2'd3 || imem_wr !== 1'b0 || prog_len !== 9'd2 ||
          cpu_rst !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_load: got err=%b code=%0d wr=%b len=%0d cpu_rst=%b busy=%b, expected 1 3 0 2 1 0",
                  err, err_code, imem_wr, prog_len, cpu_rst, busy);
      end
      tick();
      n_checks++;
      if (n_writes !== 2 || exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL abort_count: got writes=%0d pending=%0d, expected 2 0", n_writes, exp_q.size());
      end
   endtask

   task automatic test_reset_mid_run();
      do_start();
      ld_valid = 1'b1;
      ld_last  = 1'b1;
      ld_data  = 12'hABC;
      exp_q.push_back({8'd0, ld_data});
      tick();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      for (int k = 1; k <= 2; k++) begin
         instr_addr = AW'(k + 20);
         tick();
      end
      n_checks++;
      if (busy !== 1'b1 || cpu_rst !== 1'b0 || cycles !== 32'd2) begin
         n_fail++;
         $display("FAIL pre_reset_run: got busy=%b cpu_rst=%b cyc=%0d, expected 1 0 2",
                  busy, cpu_rst, cycles);
      end
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if ({cpu_rst, ld_ready, imem_wr, busy, done, err} !== 6'b100000 || err_code !== 2'd0 ||
          prog_len !== '0 || cycles !== '0 || imem_addr !== '0 || imem_wdata !== '0) begin
         n_fail++;
         $display("FAIL async_reset: got flags=%b code=%0d len=%0d cyc=%0d addr=%0h data=%0h, expected 100000 and zeros",
                  {cpu_rst, ld_ready, imem_wr, busy, done, err}, err_code, prog_len, cycles,
                  imem_addr, imem_wdata);
      end
      #2 rst = 1'b1;
      tick();
      n_checks++;
      if (busy !== 1'b0 || cpu_rst !== 1'b1 || exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL post_reset_idle: got busy=%b cpu_rst=%b pending=%0d, expected 0 1 0",
                  busy, cpu_rst, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_load_back_to_back();
      test_halt();
      test_toggle_valid();
      test_timeout();
      test_overflow();
      test_abort_load();
      test_reset_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: got no completion by 100000 ns, expected completion");
      $fatal(1, "bench time limit");
   end

endmodule
